// File: rtl/program_sequencer_pkg.sv
// Shared widths, the halt word and the sequencer state encoding for the program sequencer slice.
package prog_seq_pkg;

    localparam int INSTR_W    = 24;
    localparam int MEM_ADDR_W = 7;

    localparam logic [INSTR_W-1:0] HALT_WORD = 24'h000000;

    typedef enum logic [2:0] {
        IDLE,
        CPU_RST,
        LOAD,
        RUN,
        READ,
        DONE
    } seq_state_t;

endpackage

// File: rtl/program_sequencer_if.sv
// Link between the sequencer (master) and the processor it drives (slave).
interface program_sequencer_if;
    import prog_seq_pkg::*;

    logic                  cpu_reset;
    logic [INSTR_W-1:0]    cpu_instr;
    logic [MEM_ADDR_W-1:0] cpu_select_mem;
    logic [INSTR_W-1:0]    cpu_mem_data;
    logic                  cpu_done;

    modport master (
        output cpu_reset,
        output cpu_instr,
        output cpu_select_mem,
        input  cpu_mem_data,
        input  cpu_done
    );

    modport slave (
        input  cpu_reset,
        input  cpu_instr,
        input  cpu_select_mem,
        output cpu_mem_data,
        output cpu_done
    );

endinterface

// File: rtl/program_sequencer_instr_buffer.sv
// Instruction store: append-only write port, indexed combinational read port, word count and clear.
module instr_buffer
    import prog_seq_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [INSTR_W-1:0]       wr_data,
    input  logic                     clear,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [INSTR_W-1:0]       rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic               push;

    assign full = (count == CW'(DEPTH));

    // A clear in the same cycle as a write wins and the write is lost.
    assign push = wr_en && !full && !clear;

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            wr_ptr <= '0;
        end else if (clear) begin
            count  <= '0;
            wr_ptr <= '0;
        end else if (push) begin
            count  <= count + CW'(1);
            wr_ptr <= wr_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/program_sequencer.sv
// Loads a buffered program into the processor, runs it and reads back one memory cell.
// Define PROG_SEQ_WATCHDOG_EN to bound RUN to TIMEOUT cycles and flag timeout_err.
module program_sequencer
    import prog_seq_pkg::*;
#(
    parameter int DEPTH      = 32,
    parameter int RST_CYCLES = 3,
    parameter int TIMEOUT    = 1024,
    parameter int READ_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [INSTR_W-1:0]    wr_data,
    input  logic                  clear,
    input  logic                  start,
    input  logic [MEM_ADDR_W-1:0] result_addr,
    program_sequencer_if.master   cpu,
    output logic                  wr_full,
    output logic                  busy,
    output logic [INSTR_W-1:0]    result_data,
    output logic                  result_valid,
    output logic                  timeout_err
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int RD_W  = (READ_LAT > 0) ? $clog2(READ_LAT + 1) : 1;

    seq_state_t state, next_state;

    logic [RST_W-1:0]      rst_cnt;
    logic [CW-1:0]         load_idx;
    logic [RD_W-1:0]       rd_cnt;
    logic [CW-1:0]         count;
    logic [INSTR_W-1:0]    rd_data;
    logic                  start_ok;
    logic                  rst_last;
    logic                  load_last;
    logic                  read_last;
    logic                  cpu_reset_q;
    logic [MEM_ADDR_W-1:0] select_q;

    instr_buffer #(
        .DEPTH (DEPTH)
    ) u_buffer (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en && (state == IDLE)),
        .wr_data (wr_data),
        .clear   (clear && (state == IDLE)),
        .rd_idx  (load_idx[AW-1:0]),
        .rd_data (rd_data),
        .count   (count),
        .full    (wr_full)
    );

    assign start_ok  = start && ((state == IDLE) || (state == DONE));
    assign rst_last  = (rst_cnt == RST_W'(RST_CYCLES - 1));
    assign load_last = (load_idx == count);
    assign read_last = (rd_cnt == RD_W'(READ_LAT));

`ifdef PROG_SEQ_WATCHDOG_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] run_cnt;
    logic          run_timeout;
    logic          timeout_q;

    assign run_timeout = (state == RUN) && !cpu.cpu_done && (run_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt   <= '0;
            timeout_q <= 1'b0;
        end else begin
            run_cnt <= (state == RUN) ? run_cnt + TW'(1) : '0;
            if (start_ok) begin
                timeout_q <= 1'b0;
            end else if (run_timeout) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_ok)  next_state = CPU_RST;
            CPU_RST: if (rst_last)  next_state = LOAD;
            LOAD:    if (load_last) next_state = RUN;
            RUN: begin
                if (cpu.cpu_done) begin
                    next_state = READ;
`ifdef PROG_SEQ_WATCHDOG_EN
                end else if (run_timeout) begin
                    next_state = DONE;
`endif
                end
            end
            READ:    if (read_last) next_state = DONE;
            DONE:    if (start_ok)  next_state = CPU_RST;
            default:                next_state = IDLE;
        endcase
    end

    // Phase counters restart from zero whenever their phase is not active.
    always_ff @(posedge clk) begin
        if (reset) begin
            rst_cnt  <= '0;
            load_idx <= '0;
            rd_cnt   <= '0;
        end else begin
            rst_cnt  <= (state == CPU_RST) ? rst_cnt + RST_W'(1) : '0;
            load_idx <= (state == LOAD) ? load_idx + CW'(1) : '0;
            rd_cnt   <= (state == READ) ? rd_cnt + RD_W'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_reset_q  <= 1'b1;
            select_q     <= '0;
            result_data  <= '0;
            result_valid <= 1'b0;
        end else begin
            cpu_reset_q <= (next_state == CPU_RST);
            if (start_ok) begin
                select_q     <= result_addr;
                result_valid <= 1'b0;
            end else if ((state == READ) && read_last) begin
                result_data  <= cpu.cpu_mem_data;
                result_valid <= 1'b1;
            end
        end
    end

    assign cpu.cpu_reset      = cpu_reset_q;
    assign cpu.cpu_select_mem = select_q;
    assign cpu.cpu_instr      = ((state == LOAD) && !load_last) ? rd_data : HALT_WORD;

    assign busy = (state != IDLE) && (state != DONE);

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer with a processor memory model and instruction/result scoreboards.
module tb_program_sequencer;
    import prog_seq_pkg::*;

    localparam int DEPTH      = 32;
    localparam int RST_CYCLES = 3;
    localparam int READ_LAT   = 1;
`ifdef PROG_SEQ_WATCHDOG_EN
    localparam int TIMEOUT    = 16;
    localparam int DONE_DELAY = 8;
`else
    localparam int TIMEOUT    = 1024;
    localparam int DONE_DELAY = 20;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  wr_en;
    logic [INSTR_W-1:0]    wr_data;
    logic                  clear;
    logic                  start;
    logic [MEM_ADDR_W-1:0] result_addr;
    logic                  wr_full;
    logic                  busy;
    logic [INSTR_W-1:0]    result_data;
    logic                  result_valid;
    logic                  timeout_err;

    program_sequencer_if cpu_if();

    program_sequencer #(
        .DEPTH      (DEPTH),
        .RST_CYCLES (RST_CYCLES),
        .TIMEOUT    (TIMEOUT),
        .READ_LAT   (READ_LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .clear        (clear),
        .start        (start),
        .result_addr  (result_addr),
        .cpu          (cpu_if),
        .wr_full      (wr_full),
        .busy         (busy),
        .result_data  (result_data),
        .result_valid (result_valid),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    // Processor data memory with a one-cycle read latency.
    logic [INSTR_W-1:0] mem_model [128];
    always @(posedge clk) cpu_if.cpu_mem_data <= mem_model[cpu_if.cpu_select_mem];

    logic [INSTR_W-1:0]    model_buf [$];
    logic [INSTR_W-1:0]    exp_q [$];
    logic [INSTR_W-1:0]    res_q [$];
    logic [MEM_ADDR_W-1:0] last_addr;
    int                    checks = 0;
    int                    fails  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic w, input logic c, input logic [INSTR_W-1:0] d);
        wr_en   = w;
        clear   = c;
        wr_data = d;
        if (c) model_buf.delete();
        else if (w && model_buf.size() < DEPTH) model_buf.push_back(d);
        next_cycle();
        wr_en = 1'b0;
        clear = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        checkOutput({tag, "_cpu_reset"}, cpu_if.cpu_reset, 1);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_instr"}, cpu_if.cpu_instr, 0);
        checkOutput({tag, "_select"}, cpu_if.cpu_select_mem, 0);
        checkOutput({tag, "_rdata"}, result_data, 0);
        checkOutput({tag, "_rvalid"}, result_valid, 0);
        checkOutput({tag, "_timeout"}, timeout_err, 0);
        checkOutput({tag, "_wr_full"}, wr_full, 0);
        next_cycle();
        @(negedge clk);
        checkOutput({tag, "_cpu_reset_off"}, cpu_if.cpu_reset, 0);
        checkOutput({tag, "_busy_idle"}, busy, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        model_buf.delete();
        check_reset_state("reset");
    endtask

    // Accepts a start, checks the processor reset window and every loaded word;
    // abort_at >= 0 asserts reset while that word is on cpu_instr.
    task automatic start_and_load(input logic [MEM_ADDR_W-1:0] addr, input int abort_at);
        logic [INSTR_W-1:0] exp;
        int idx;
        exp_q.delete();
        foreach (model_buf[i]) exp_q.push_back(model_buf[i]);
        exp_q.push_back(HALT_WORD);
        res_q.push_back(mem_model[addr]);
        last_addr   = addr;
        start       = 1'b1;
        result_addr = addr;
        next_cycle();
        start       = 1'b0;
        result_addr = '0;
        for (int i = 0; i < RST_CYCLES; i++) begin
            @(negedge clk);
            checkOutput("rst_cpu_reset", cpu_if.cpu_reset, 1);
            checkOutput("rst_busy", busy, 1);
            checkOutput("rst_instr", cpu_if.cpu_instr, 0);
            checkOutput("rst_select", cpu_if.cpu_select_mem, addr);
            checkOutput("rst_rvalid", result_valid, 0);
            next_cycle();
        end
        idx = 0;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            @(negedge clk);
            checkOutput("load_word", cpu_if.cpu_instr, exp);
            checkOutput("load_cpu_reset", cpu_if.cpu_reset, 0);
            checkOutput("load_busy", busy, 1);
            if (idx == abort_at) begin
                reset = 1'b1;
                next_cycle();
                reset = 1'b0;
                model_buf.delete();
                exp_q.delete();
                res_q.delete();
                check_reset_state("abort");
                return;
            end
            idx++;
            next_cycle();
        end
        @(negedge clk);
        checkOutput("run_instr", cpu_if.cpu_instr, 0);
        checkOutput("run_busy", busy, 1);
        checkOutput("run_cpu_reset", cpu_if.cpu_reset, 0);
    endtask

    // Drives cpu_done in RUN cycle done_delay and checks the READ window and result.
    task automatic finish_run(input int done_delay, input bit poke);
        logic [INSTR_W-1:0] exp;
        for (int i = 1; i <= done_delay; i++) begin
            next_cycle();
            if (poke && i == 5) begin
                start       = 1'b1;
                wr_en       = 1'b1;
                clear       = 1'b1;
                wr_data     = 24'hBADBAD;
                result_addr = 7'd5;
            end
            if (poke && i == 6) begin
                start       = 1'b0;
                wr_en       = 1'b0;
                clear       = 1'b0;
                result_addr = '0;
                @(negedge clk);
                checkOutput("start_in_run_cpu_reset", cpu_if.cpu_reset, 0);
                checkOutput("start_in_run_busy", busy, 1);
                checkOutput("start_in_run_select", cpu_if.cpu_select_mem, last_addr);
            end
        end
        cpu_if.cpu_done = 1'b1;
        next_cycle();
        cpu_if.cpu_done = 1'b0;
        for (int i = 0; i <= READ_LAT; i++) begin
            @(negedge clk);
            checkOutput("read_rvalid", result_valid, 0);
            checkOutput("read_busy", busy, 1);
            next_cycle();
        end
        exp = res_q.pop_front();
        @(negedge clk);
        checkOutput("done_rvalid", result_valid, 1);
        checkOutput("done_rdata", result_data, exp);
        checkOutput("done_busy", busy, 0);
        checkOutput("done_timeout", timeout_err, 0);
        next_cycle();
        @(negedge clk);
        checkOutput("done_hold_rvalid", result_valid, 1);
        checkOutput("done_hold_rdata", result_data, exp);
    endtask

    initial begin
        reset           = 1'b1;
        wr_en           = 1'b0;
        wr_data         = '0;
        clear           = 1'b0;
        start           = 1'b0;
        result_addr     = '0;
        cpu_if.cpu_done = 1'b0;
        for (int i = 0; i < 128; i++) mem_model[i] = 24'(i * 24'h010203);
        mem_model[40] = 24'h000022;

        $display("[TB] reset state");
        do_reset();

        $display("[TB] nine-word program, result cell 40");
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, 24'(24'hA00000 + i * 17));
        start_and_load(7'd40, -1);
        finish_run(DONE_DELAY, 1'b1);
        $display("[TB] replay from DONE");
        start_and_load(7'd40, -1);
        finish_run(DONE_DELAY, 1'b0);

        $display("[TB] fill to depth and overflow");
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) begin
            applyStimulus(1'b1, 1'b0, 24'(24'h300000 + i * 24'h000101));
            @(negedge clk);
            checkOutput("wr_full", wr_full, (model_buf.size() == DEPTH));
        end
        start_and_load(7'd100, -1);
        finish_run(DONE_DELAY, 1'b0);
        $display("[TB] reset during fifth load word");
        start_and_load(7'd100, 4);

        $display("[TB] empty buffer run");
        start_and_load(7'd41, -1);
        finish_run(DONE_DELAY, 1'b0);

        $display("[TB] clear with write");
        do_reset();
        applyStimulus(1'b1, 1'b0, 24'h111111);
        applyStimulus(1'b1, 1'b0, 24'h222222);
        applyStimulus(1'b1, 1'b1, 24'h333333);
        applyStimulus(1'b1, 1'b0, 24'h444444);
        start_and_load(7'd9, -1);
        finish_run(DONE_DELAY, 1'b0);

`ifdef PROG_SEQ_WATCHDOG_EN
        $display("[TB] watchdog");
        do_reset();
        start_and_load(7'd3, -1);
        for (int i = 1; i < TIMEOUT; i++) begin
            next_cycle();
            @(negedge clk);
            checkOutput("wd_run_busy", busy, 1);
            checkOutput("wd_run_timeout", timeout_err, 0);
        end
        next_cycle();
        @(negedge clk);
        checkOutput("wd_done_busy", busy, 0);
        checkOutput("wd_timeout", timeout_err, 1);
        checkOutput("wd_rvalid", result_valid, 0);
        void'(res_q.pop_front());
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        checkOutput("wd_restart_timeout", timeout_err, 0);
        checkOutput("wd_restart_cpu_reset", cpu_if.cpu_reset, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
